// File: rtl/game_tick_pkg.sv
// ----------------------------------------------------------------------------
// game_tick_pkg
// Shared types and constants for the game-tick sink.
//   tick_state_t : sink state (IDLE, RUN, DRAIN)
//   EDGE_RISING  : only rising edges of the tick level are ticks
//   EDGE_BOTH    : every level change of the tick line is a tick
// ----------------------------------------------------------------------------
package game_tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tick_state_t;

    localparam int EDGE_RISING = 0;
    localparam int EDGE_BOTH   = 1;

endpackage : game_tick_pkg

// File: rtl/tick_edge_det.sv
// ----------------------------------------------------------------------------
// tick_edge_det
// Turns the divided tick level into a one-cycle edge strobe.
// Ports:
//   i_clk   : system clock
//   i_level : tick level, same clock domain, registered at its source
//   o_edge  : combinational edge strobe (rising only, or both, by EDGE_MODE)
// ----------------------------------------------------------------------------
module tick_edge_det
    import game_tick_pkg::*;
#(
    parameter int EDGE_MODE = EDGE_RISING
) (
    input  logic i_clk,
    input  logic i_level,
    output logic o_edge
);

    logic r_prev_level;

    // There is deliberately no reset here: reset must load the live level so
    // the first edge after release is a genuine level change, and that is
    // exactly what the normal every-cycle update already does.
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        r_prev_level <= i_level;
    end

    assign o_edge = (EDGE_MODE == EDGE_BOTH) ? (i_level ^ r_prev_level)
                                             : (i_level & ~r_prev_level);

endmodule : tick_edge_det

// File: rtl/game_tick_sink.sv
// ----------------------------------------------------------------------------
// game_tick_sink
// Consumer end of the divided game-tick line. Converts tick level changes
// into tick tokens delivered over valid/ready, buffering them in a
// saturating pending counter, flagging overrun, counting delivered ticks and
// raising a watchdog flag when the tick line stops toggling.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_tick_in       : divided tick level
//   i_enable        : 1 = accept ticks, 0 = stop accepting and drain
//   i_tick_ready    : game logic accepts a tick this cycle
//   i_clr_overrun   : one-cycle pulse clearing the overrun flag
//   o_tick_valid    : a tick is pending and deliverable
//   o_pending       : buffered tick count
//   o_tick_cnt      : delivered ticks, wraps silently
//   o_overrun       : sticky, a tick was dropped at saturation
//   o_stalled       : watchdog expired
//   o_busy          : state is not IDLE
// ----------------------------------------------------------------------------
module game_tick_sink
    import game_tick_pkg::*;
#(
    parameter int EDGE_MODE    = EDGE_RISING,
    parameter int MAX_PENDING  = 3,
    parameter int PEND_BITS    = 4,
    parameter int CNT_BITS     = 16,
    parameter int STALL_CYCLES = 40000000,
    parameter int STALL_BITS   = 26
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tick_in,
    input  logic                 i_enable,
    input  logic                 i_tick_ready,
    input  logic                 i_clr_overrun,
    output logic                 o_tick_valid,
    output logic [PEND_BITS-1:0] o_pending,
    output logic [CNT_BITS-1:0]  o_tick_cnt,
    output logic                 o_overrun,
    output logic                 o_stalled,
    output logic                 o_busy
);

    localparam logic [PEND_BITS-1:0]  PEND_MAX = PEND_BITS'(MAX_PENDING);
    localparam logic [STALL_BITS-1:0] WD_LIMIT = STALL_BITS'(STALL_CYCLES);

    tick_state_t           r_state, w_state_nxt;
    logic [PEND_BITS-1:0]  r_pending, w_pending_nxt;
    logic [STALL_BITS-1:0] r_watchdog, w_watchdog_nxt;
    logic [CNT_BITS-1:0]   r_tick_cnt;
    logic                  r_tick_valid, r_overrun, r_stalled, r_busy;
    logic                  w_edge, w_xfer, w_accept, w_drop;

    tick_edge_det #(
        .EDGE_MODE (EDGE_MODE)
    ) u_edge_det (
        .i_clk   (i_clk),
        .i_level (i_tick_in),
        .o_edge  (w_edge)
    );

    assign w_xfer   = r_tick_valid & i_tick_ready;
    assign w_accept = (r_state == RUN) & i_enable & w_edge;
    // A transfer in the same cycle frees a slot, so only a full buffer with
    // no outgoing tick loses the incoming one.
    assign w_drop   = w_accept & ~w_xfer & (r_pending == PEND_MAX);

    // NOTE: every signal written here gets a default first, so no latches.
    always_comb begin
        w_pending_nxt = r_pending;
        unique case ({w_accept & ~w_drop, w_xfer})
            2'b10:   w_pending_nxt = r_pending + 1'b1;
            2'b01:   w_pending_nxt = r_pending - 1'b1;
            default: w_pending_nxt = r_pending;
        endcase

        // Exit decisions look at the post-transfer count, so the last
        // delivered tick moves straight to IDLE.
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (i_enable) w_state_nxt = RUN;
            RUN:   if (!i_enable) w_state_nxt = (w_pending_nxt != '0) ? DRAIN : IDLE;
            DRAIN: begin
                if (i_enable)                 w_state_nxt = RUN;
                else if (w_pending_nxt == '0) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_state_nxt == IDLE) w_pending_nxt = '0;

        // The watchdog only runs while staying in RUN; any raw edge restarts it.
        w_watchdog_nxt = '0;
        if (r_state == RUN && w_state_nxt == RUN) begin
            if (w_edge)                     w_watchdog_nxt = '0;
            else if (r_watchdog != WD_LIMIT) w_watchdog_nxt = r_watchdog + 1'b1;
            else                            w_watchdog_nxt = r_watchdog;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Flags are registered from next-state values so they line up with the
    // state and counters they describe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending    <= '0;
            r_watchdog   <= '0;
            r_tick_cnt   <= '0;
            r_tick_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_stalled    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_watchdog   <= w_watchdog_nxt;
            r_tick_valid <= (w_pending_nxt != '0) && (w_state_nxt != IDLE);
            r_stalled    <= (w_watchdog_nxt == WD_LIMIT);
            r_busy       <= (w_state_nxt != IDLE);
            if (w_xfer) r_tick_cnt <= r_tick_cnt + 1'b1;
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop)             r_overrun <= 1'b1;
            else if (i_clr_overrun) r_overrun <= 1'b0;
        end
    end

    assign o_tick_valid = r_tick_valid;
    assign o_pending    = r_pending;
    assign o_tick_cnt   = r_tick_cnt;
    assign o_overrun    = r_overrun;
    assign o_stalled    = r_stalled;
    assign o_busy       = r_busy;

endmodule : game_tick_sink

// File: tb/tb_game_tick_sink.sv
// ----------------------------------------------------------------------------
// tb_game_tick_sink
// Self-checking bench: directed scenarios followed by random stimulus, with
// every cycle of the rising-edge instance compared against a behavioural
// model; a second instance in both-edge mode gets a short directed check.
// ----------------------------------------------------------------------------
module tb_game_tick_sink;

    localparam int MAXP  = 3;
    localparam int STALL = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst1, tin, en, rdy, clr;

    logic        v0, o0, s0, b0;
    logic [3:0]  p0;
    logic [15:0] c0;
    logic        v1, o1, s1, b1;
    logic [3:0]  p1;
    logic [15:0] c1;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Model state: m_state 0 = idle, 1 = run, 2 = drain.
    int m_state, m_pend, m_cnt, m_ovr, m_wd;
    bit m_prev;

    game_tick_sink #(
        .EDGE_MODE(0), .MAX_PENDING(MAXP), .PEND_BITS(4), .CNT_BITS(16),
        .STALL_CYCLES(STALL), .STALL_BITS(26)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .i_tick_in(tin), .i_enable(en),
        .i_tick_ready(rdy), .i_clr_overrun(clr),
        .o_tick_valid(v0), .o_pending(p0), .o_tick_cnt(c0),
        .o_overrun(o0), .o_stalled(s0), .o_busy(b0)
    );

    game_tick_sink #(
        .EDGE_MODE(1), .MAX_PENDING(MAXP), .PEND_BITS(4), .CNT_BITS(16),
        .STALL_CYCLES(STALL), .STALL_BITS(26)
    ) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_tick_in(tin), .i_enable(en),
        .i_tick_ready(rdy), .i_clr_overrun(clr),
        .o_tick_valid(v1), .o_pending(p1), .o_tick_cnt(c1),
        .o_overrun(o1), .o_stalled(s1), .o_busy(b1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advances the model by one clock using the inputs as they stand now.
    task automatic model_update();
        bit rise, xfer, drop;
        int pend, nstate;
        if (rst) begin
            m_state = 0; m_pend = 0; m_cnt = 0; m_ovr = 0; m_wd = 0;
            m_prev  = tin;
            return;
        end
        rise = tin && !m_prev;
        xfer = (m_pend > 0) && (m_state != 0) && rdy;
        drop = 1'b0;
        pend = m_pend;
        if (xfer) begin
            pend  = pend - 1;
            m_cnt = (m_cnt + 1) % 65536;
        end
        if (m_state == 1 && en && rise) begin
            if (pend < MAXP) pend = pend + 1;
            else             drop = 1'b1;
        end
        if (drop)     m_ovr = 1;
        else if (clr) m_ovr = 0;
        nstate = m_state;
        case (m_state)
            0: if (en) nstate = 1;
            1: if (!en) nstate = (pend > 0) ? 2 : 0;
            default: begin
                if (en)             nstate = 1;
                else if (pend == 0) nstate = 0;
            end
        endcase
        if (m_state == 1 && nstate == 1)
            m_wd = rise ? 0 : ((m_wd < STALL) ? m_wd + 1 : STALL);
        else
            m_wd = 0;
        m_state = nstate;
        m_pend  = pend;
        m_prev  = tin;
    endtask

    task automatic compare_all();
        check("valid",   32'(v0), 32'((m_pend > 0) && (m_state != 0)));
        check("pending", 32'(p0), 32'(m_pend));
        check("tick_cnt", 32'(c0), 32'(m_cnt));
        check("overrun", 32'(o0), 32'(m_ovr));
        check("stalled", 32'(s0), 32'(m_wd == STALL));
        check("busy",    32'(b0), 32'(m_state != 0));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rise_fall(input int hi, input int lo);
        tin = 1'b1; cycles(hi);
        tin = 1'b0; cycles(lo);
    endtask

    initial begin
        rst = 1'b1; rst1 = 1'b1; tin = 1'b0; en = 1'b0; rdy = 1'b0; clr = 1'b0;
        m_state = 0; m_pend = 0; m_cnt = 0; m_ovr = 0; m_wd = 0; m_prev = 1'b0;

        // Reset values
        cycles(3);
        check("rst_valid", 32'(v0), 0);
        check("rst_pending", 32'(p0), 0);
        check("rst_cnt", 32'(c0), 0);
        check("rst_overrun", 32'(o0), 0);
        check("rst_stalled", 32'(s0), 0);
        check("rst_busy", 32'(b0), 0);

        // Basic delivery: one-cycle valid pulse after each rise
        rst = 1'b0; en = 1'b1; rdy = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            tin = 1'b1; step();
            check("basic_valid_hi", 32'(v0), 1);
            step();
            check("basic_valid_lo", 32'(v0), 0);
            cycles(3);
            tin = 1'b0; cycles(5);
        end
        check("basic_cnt", 32'(c0), 4);
        check("basic_pending", 32'(p0), 0);
        check("basic_overrun", 32'(o0), 0);

        // Saturation
        rst = 1'b1; step(); rst = 1'b0; step();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) rise_fall(2, 2);
        check("sat_pending3", 32'(p0), 3);
        check("sat_no_ovr_yet", 32'(o0), 0);
        rise_fall(2, 2);
        check("sat_ovr_4th", 32'(o0), 1);
        rise_fall(2, 2);
        check("sat_pending_hold", 32'(p0), 3);
        rdy = 1'b1; cycles(6);
        check("sat_cnt3", 32'(c0), 3);
        check("sat_drained", 32'(p0), 0);
        clr = 1'b1; step(); clr = 1'b0;
        check("sat_clr", 32'(o0), 0);

        // Simultaneous accepted edge and transfer at saturation
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) rise_fall(2, 2);
        rdy = 1'b1; tin = 1'b1; step(); rdy = 1'b0;
        check("simul_pending", 32'(p0), 3);
        check("simul_overrun", 32'(o0), 0);
        tin = 1'b0; cycles(2);
        // Clear coincident with a drop: set wins
        tin = 1'b1; clr = 1'b1; step(); clr = 1'b0;
        check("clr_vs_drop", 32'(o0), 1);
        tin = 1'b0; cycles(2);

        // Drain
        rdy = 1'b1; step(); rdy = 1'b0;
        check("drain_pending2", 32'(p0), 2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tin = ~tin; step();
        end
        check("drain_busy", 32'(b0), 1);
        check("drain_valid", 32'(v0), 1);
        check("drain_pending", 32'(p0), 2);
        rdy = 1'b1; cycles(2);
        check("drain_done_pending", 32'(p0), 0);
        check("drain_done_busy", 32'(b0), 0);
        check("drain_done_valid", 32'(v0), 0);

        // Watchdog
        tin = 1'b0; step();
        en = 1'b1; step();
        cycles(19);
        check("wd_not_yet", 32'(s0), 0);
        step();
        check("wd_stalled", 32'(s0), 1);
        cycles(5);
        check("wd_held", 32'(s0), 1);
        rdy = 1'b0;
        tin = 1'b1; step();
        check("wd_cleared", 32'(s0), 0);

        // Reset mid-operation with the tick line high
        tin = 1'b0; step();
        tin = 1'b1; step();
        check("pre_rst_pending", 32'(p0), 2);
        rst = 1'b1; step();
        check("mid_rst_valid", 32'(v0), 0);
        check("mid_rst_pending", 32'(p0), 0);
        check("mid_rst_busy", 32'(b0), 0);
        rst = 1'b0; rdy = 1'b1; cycles(5);
        check("post_rst_no_tick", 32'(p0), 0);
        check("post_rst_cnt", 32'(c0), 0);
        tin = 1'b0; cycles(2);
        tin = 1'b1; step();
        check("post_rst_real_tick", 32'(v0), 1);
        step();
        check("post_rst_cnt1", 32'(c0), 1);

        // Random traffic, busy tick line
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(2) == 0) tin = ~tin;
            rdy = ($urandom_range(1) == 1);
            if ($urandom_range(19) == 0) en = ~en;
            clr = ($urandom_range(15) == 0);
            rst = ($urandom_range(399) == 0);
            step();
        end
        // Random traffic, sparse tick line to exercise the watchdog
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) tin = ~tin;
            rdy = ($urandom_range(3) == 0);
            if ($urandom_range(99) == 0) en = ~en;
            clr = ($urandom_range(31) == 0);
            step();
        end

        // Both-edge instance
        rst = 1'b0; clr = 1'b0; tin = 1'b0; step();
        rst1 = 1'b0; en = 1'b1; rdy = 1'b1; step();
        tin = 1'b1; cycles(3);
        tin = 1'b0; cycles(3);
        tin = 1'b1; cycles(3);
        check("both_cnt3", 32'(c1), 3);
        check("both_pending", 32'(p1), 0);
        check("both_valid", 32'(v1), 0);
        check("both_overrun", 32'(o1), 0);
        check("both_stalled", 32'(s1), 0);
        check("both_busy", 32'(b1), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_game_tick_sink
